accel_sampler: RTL

- Upstream stage of the velocity integrator.
- Converts raw signed accelerometer samples into bias-corrected, block-averaged acceleration `a` plus elapsed time `dt`.
- Drives the integrator's level `enable` / `busy` handshake so each averaged block is integrated exactly once.
- Performs power-up and on-demand bias calibration. Buffers one pending block while the integrator is busy.

---
 rtl/accel_sampler.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/accel_sampler.sv
// accel_sampler: calibrates accelerometer bias, block-averages samples and
// hands (a, dt) to the velocity integrator over a level enable/busy handshake.
// Ports: clk, rst (async active-low), sample_valid/sample (raw signed input),
//   recal (recalibrate pulse), integ_busy (integrator busy),
//   a/dt/integ_en (to integrator), calibrated, bias, overrun (sticky).
module accel_sampler #(
    parameter int          CAL_SHIFT = 8,
    parameter int          AVG_SHIFT = 2,
    parameter int          TICK_DIV  = 500,
    parameter logic [15:0] DEADBAND  = 16'd8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic signed [15:0] sample,
    input  logic               recal,
    input  logic               integ_busy,
    output logic signed [15:0] a,
    output logic        [15:0] dt,
    output logic               integ_en,
    output logic               calibrated,
    output logic signed [15:0] bias,
    output logic               overrun
);

    localparam int AW = 17 + AVG_SHIFT;
    localparam int CW = CAL_SHIFT + 1;
    localparam int BW = AVG_SHIFT + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] S_CAL   = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [CW-1:0] CAL_LAST   = CW'(2 ** CAL_SHIFT - 1);
    localparam logic [BW-1:0] BLK_LAST   = BW'(2 ** AVG_SHIFT - 1);
    localparam logic [TW-1:0] PRESC_LAST = TW'(TICK_DIV - 1);

    logic [1:0]           state_q, state_d;
    logic signed [31:0]   cal_acc_q, cal_acc_d;
    logic [CW-1:0]        cal_cnt_q, cal_cnt_d;
    logic                 cal_fin_q, cal_fin_d;
    logic signed [AW-1:0] blk_acc_q, blk_acc_d;
    logic [BW-1:0]        blk_cnt_q, blk_cnt_d;
    logic                 blk_done_q, blk_done_d;
    logic [15:0]          blk_q, blk_d;
    logic [15:0]          pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [TW-1:0]        presc_q, presc_d;
    logic [15:0]          dt_cnt_q, dt_cnt_d;
    logic [15:0]          a_q, a_d;
    logic [15:0]          dt_q, dt_d;
    logic                 en_q, en_d;
    logic                 cal_q, cal_d;
    logic [15:0]          bias_q, bias_d;
    logic                 ovr_q, ovr_d;
    logic                 rcl_q, rcl_d;

    logic                 wrap, act, issue;
    logic                 blk_take, blk_last;
    logic signed [31:0]   cal_sum;
    logic [15:0]          bias_new;
    logic signed [16:0]   diff;
    logic signed [AW-1:0] blk_sum;
    logic signed [16:0]   avg17;
    logic [15:0]          sat, mag, blk_res;

    assign wrap = (presc_q == PRESC_LAST);

    // A pending recal is honoured in CAL/RUN, or as WAIT hands back to RUN.
    assign act = (recal | rcl_q) &
                 ((state_q == S_CAL) | (state_q == S_RUN) |
                  ((state_q == S_WAIT) & ~integ_busy));

    assign issue = (state_q == S_RUN) & pend_valid_q & ~act;

    assign cal_sum  = cal_acc_q + 32'(sample);
    assign bias_new = 16'(cal_sum >>> CAL_SHIFT);

    assign blk_take = sample_valid & ~act & (state_q != S_CAL);
    assign blk_last = blk_take & (blk_cnt_q == BLK_LAST);
    assign diff     = 17'(sample) - 17'($signed(bias_q));
    assign blk_sum  = blk_acc_q + AW'(diff);
    assign avg17    = 17'(blk_sum >>> AVG_SHIFT);

    // The average is a 17-bit value; clamp when it leaves 16-bit range.
    assign sat = (avg17[16] ^ avg17[15])
               ? (avg17[16] ? 16'h8000 : 16'h7FFF)
               : avg17[15:0];
    assign mag     = sat[15] ? (~sat + 16'd1) : sat;
    assign blk_res = (mag < DEADBAND) ? 16'd0 : sat;

    always_comb begin
        state_d      = state_q;
        cal_acc_d    = cal_acc_q;
        cal_cnt_d    = cal_cnt_q;
        cal_fin_d    = 1'b0;
        blk_acc_d    = blk_acc_q;
        blk_cnt_d    = blk_cnt_q;
        blk_done_d   = 1'b0;
        blk_d        = blk_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        presc_d      = wrap ? '0 : presc_q + 1'b1;
        dt_cnt_d     = (wrap && dt_cnt_q != 16'hFFFF)
                     ? dt_cnt_q + 16'd1 : dt_cnt_q;
        a_d          = a_q;
        dt_d         = dt_q;
        en_d         = en_q;
        cal_d        = cal_q | cal_fin_q;
        bias_d       = bias_q;
        ovr_d        = ovr_q;
        rcl_d        = rcl_q | recal;

        if (blk_take) begin
            if (blk_last) begin
                blk_acc_d  = '0;
                blk_cnt_d  = '0;
                blk_d      = blk_res;
                blk_done_d = 1'b1;
            end else begin
                blk_acc_d = blk_sum;
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end

        // A fresh block lands in pend; it only overruns if the old
        // one is not being issued on this same edge.
        if (blk_done_q) begin
            pend_d       = blk_q;
            pend_valid_d = 1'b1;
            if (pend_valid_q && !issue) ovr_d = 1'b1;
        end else if (issue) begin
            pend_valid_d = 1'b0;
        end

        unique case (state_q)
            S_CAL: begin
                if (sample_valid && !act) begin
                    if (cal_cnt_q == CAL_LAST) begin
                        bias_d    = bias_new;
                        cal_fin_d = 1'b1;
                        cal_acc_d = '0;
                        cal_cnt_d = '0;
                        presc_d   = '0;
                        dt_cnt_d  = '0;
                        blk_acc_d = '0;
                        blk_cnt_d = '0;
                        state_d   = S_RUN;
                    end else begin
                        cal_acc_d = cal_sum;
                        cal_cnt_d = cal_cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    a_d      = pend_q;
                    dt_d     = dt_cnt_q;
                    dt_cnt_d = wrap ? 16'd1 : 16'd0;
                    en_d     = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (integ_busy) begin
                    en_d    = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!integ_busy) state_d = S_RUN;
            end
            default: state_d = S_CAL;
        endcase

        if (act) begin
            state_d      = S_CAL;
            cal_acc_d    = '0;
            cal_cnt_d    = '0;
            cal_fin_d    = 1'b0;
            cal_d        = 1'b0;
            blk_acc_d    = '0;
            blk_cnt_d    = '0;
            blk_done_d   = 1'b0;
            pend_valid_d = 1'b0;
            en_d         = 1'b0;
            ovr_d        = 1'b0;
            rcl_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_CAL;
            cal_acc_q    <= '0;
            cal_cnt_q    <= '0;
            cal_fin_q    <= 1'b0;
            blk_acc_q    <= '0;
            blk_cnt_q    <= '0;
            blk_done_q   <= 1'b0;
            blk_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            presc_q      <= '0;
            dt_cnt_q     <= '0;
            a_q          <= '0;
            dt_q         <= '0;
            en_q         <= 1'b0;
            cal_q        <= 1'b0;
            bias_q       <= '0;
            ovr_q        <= 1'b0;
            rcl_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cal_acc_q    <= cal_acc_d;
            cal_cnt_q    <= cal_cnt_d;
            cal_fin_q    <= cal_fin_d;
            blk_acc_q    <= blk_acc_d;
            blk_cnt_q    <= blk_cnt_d;
            blk_done_q   <= blk_done_d;
            blk_q        <= blk_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            presc_q      <= presc_d;
            dt_cnt_q     <= dt_cnt_d;
            a_q          <= a_d;
            dt_q         <= dt_d;
            en_q         <= en_d;
            cal_q        <= cal_d;
            bias_q       <= bias_d;
            ovr_q        <= ovr_d;
            rcl_q        <= rcl_d;
        end
    end

    assign a          = a_q;
    assign dt         = dt_q;
    assign integ_en   = en_q;
    assign calibrated = cal_q;
    assign bias       = bias_q;
    assign overrun    = ovr_q;

endmodule
